// File: rtl/uart_32x.sv
// 8N1 full-duplex UART clocked at CLKS_PER_BIT times the baud rate.
// TX has a single-entry holding register; RX uses a 2-flop input synchronizer.
module uart_32x #(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic       clk32,
    input  logic       reset_,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] txdata,
    input  logic       tx_enable,
    output logic [7:0] rxdata,
    output logic       rx_enable
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          tx_st, tx_st_d;
    logic [CW-1:0]   tx_cnt, tx_cnt_d;
    logic [2:0]      tx_bit, tx_bit_d;
    logic [7:0]      tx_sh, tx_sh_d;
    logic [7:0]      hold, hold_d;
    logic            hold_full, hold_full_d;
    logic            tx_d;

    state_t          rx_st, rx_st_d;
    logic [CW-1:0]   rx_cnt, rx_cnt_d;
    logic [2:0]      rx_bit, rx_bit_d;
    logic [7:0]      rx_sh, rx_sh_d;
    logic            rx_s1, rx_s2;
    logic [7:0]      rxdata_d;
    logic            rx_en_d;

    always_comb begin
        tx_st_d     = tx_st;
        tx_cnt_d    = tx_cnt;
        tx_bit_d    = tx_bit;
        tx_sh_d     = tx_sh;
        hold_d      = hold;
        hold_full_d = hold_full;
        tx_d        = 1'b1;

        if (tx_st != IDLE && tx_enable) begin
            hold_d      = txdata;
            hold_full_d = 1'b1;
        end

        case (tx_st)
            IDLE: begin
                if (tx_enable) begin
                    tx_st_d  = START;
                    tx_sh_d  = txdata;
                    tx_cnt_d = '0;
                end
            end
            START: begin
                tx_cnt_d = tx_cnt + 1'b1;
                if (tx_cnt == LAST) begin
                    tx_st_d  = DATA;
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                end
            end
            DATA: begin
                tx_cnt_d = tx_cnt + 1'b1;
                if (tx_cnt == LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh[7:1]};
                    tx_bit_d = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_st_d = STOP;
                end
            end
            STOP: begin
                tx_cnt_d = tx_cnt + 1'b1;
                if (tx_cnt == LAST) begin
                    tx_cnt_d = '0;
                    // A request landing on this very cycle is already in hold_d.
                    if (hold_full_d) begin
                        tx_st_d     = START;
                        tx_sh_d     = hold_d;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_st_d = IDLE;
                    end
                end
            end
            default: tx_st_d = IDLE;
        endcase

        case (tx_st_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (!reset_) begin
            tx_st     <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
        end else begin
            tx_st     <= tx_st_d;
            tx_cnt    <= tx_cnt_d;
            tx_bit    <= tx_bit_d;
            tx_sh     <= tx_sh_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            tx        <= tx_d;
        end
    end

    always_comb begin
        rx_st_d  = rx_st;
        rx_cnt_d = rx_cnt;
        rx_bit_d = rx_bit;
        rx_sh_d  = rx_sh;
        rxdata_d = rxdata;
        rx_en_d  = 1'b0;

        case (rx_st)
            IDLE: begin
                if (!rx_s2) begin
                    rx_st_d  = START;
                    rx_cnt_d = '0;
                end
            end
            START: begin
                rx_cnt_d = rx_cnt + 1'b1;
                if (rx_cnt == MID) begin
                    rx_cnt_d = '0;
                    if (rx_s2) begin
                        rx_st_d = IDLE;
                    end else begin
                        rx_st_d  = DATA;
                        rx_bit_d = '0;
                    end
                end
            end
            DATA: begin
                rx_cnt_d = rx_cnt + 1'b1;
                if (rx_cnt == LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2, rx_sh[7:1]};
                    rx_bit_d = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st_d = STOP;
                end
            end
            STOP: begin
                rx_cnt_d = rx_cnt + 1'b1;
                if (rx_cnt == LAST) begin
                    // Back to IDLE at the stop midpoint to catch an early start.
                    rx_cnt_d = '0;
                    rx_st_d  = IDLE;
                    if (rx_s2) begin
                        rxdata_d = rx_sh;
                        rx_en_d  = 1'b1;
                    end
                end
            end
            default: rx_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (!reset_) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_st     <= IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rxdata    <= '0;
            rx_enable <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_st     <= rx_st_d;
            rx_cnt    <= rx_cnt_d;
            rx_bit    <= rx_bit_d;
            rx_sh     <= rx_sh_d;
            rxdata    <= rxdata_d;
            rx_enable <= rx_en_d;
        end
    end

endmodule

// File: tb/tb_uart_32x.sv
// Directed and randomized checks of uart_32x against a frame-level model.
// Loopback is selected by routing tx back onto rx.
module tb_uart_32x;

    logic       clk32 = 1'b0;
    logic       reset_;
    logic       rx;
    logic       tx;
    logic [7:0] txdata;
    logic       tx_enable;
    logic [7:0] rxdata;
    logic       rx_enable;
    logic       loop;
    logic       rx_drv;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;

    always #5 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;
    always @(posedge clk32) if (rx_enable === 1'b1) pulses <= pulses + 1;

    assign rx = loop ? tx : rx_drv;

    uart_32x #(.CLKS_PER_BIT(32)) dut (
        .clk32(clk32),
        .reset_(reset_),
        .rx(rx),
        .tx(tx),
        .txdata(txdata),
        .tx_enable(tx_enable),
        .rxdata(rxdata),
        .rx_enable(rx_enable)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk32);
    endtask

    // Expected line level k clocks after the strobe edge.
    function automatic logic tx_line(input logic [7:0] b, input int k);
        if (k < 32) return 1'b0;
        if (k < 288) return b[(k - 32) / 32];
        return 1'b1;
    endfunction

    task automatic strobe(input logic [7:0] b);
        txdata = b;
        tx_enable = 1'b1;
        tick(1);
        tx_enable = 1'b0;
    endtask

    task automatic tx_frame_check(input logic [7:0] b, input string tag);
        int bad;
        bad = 0;
        strobe(b);
        for (int k = 0; k < 320; k++) begin
            if (tx !== tx_line(b, k)) bad++;
            tick(1);
        end
        chk({tag, " bad clocks"}, bad, 0);
        chk({tag, " idle after"}, tx, 1'b1);
    endtask

    task automatic wait_rx(input int budget, output int lat, output logic ok);
        lat = 0;
        ok = 1'b0;
        while (lat < budget) begin
            if (rx_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
            lat++;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int j = 0; j < 10; j++) begin
            if (j == 0) rx_drv = 1'b0;
            else if (j == 9) rx_drv = stop;
            else rx_drv = b[j-1];
            tick(32);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int         lat;
        int         p0;
        int         bad;
        int         n_rx;
        int         last_cyc;
        logic       ok;
        logic       good;
        logic [7:0] exp;
        logic [7:0] last_good;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] q[$];

        reset_ = 1'b0;
        tx_enable = 1'b0;
        txdata = 8'h00;
        loop = 1'b0;
        rx_drv = 1'b1;
        tick(5);
        chk("reset tx", tx, 1'b1);
        chk("reset rxdata", rxdata, 8'h00);
        chk("reset rx_enable", rx_enable, 1'b0);
        reset_ = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1) bad++;
            tick(1);
        end
        chk("idle tx after release", bad, 0);

        tx_frame_check(8'hA5, "tx A5");
        for (int i = 0; i < 3; i++) begin
            tick($urandom_range(0, 5));
            tx_frame_check(8'($urandom), "tx rand");
        end

        loop = 1'b1;
        tick(10);
        p0 = pulses;
        strobe(8'h00);
        wait_rx(400, lat, ok);
        chk("lb0 seen", ok, 1'b1);
        chk("lb0 latency window", (lat >= 300 && lat <= 315), 1'b1);
        chk("lb0 rxdata", rxdata, 8'h00);
        tick(60);
        chk("lb0 pulse count", pulses - p0, 1);

        n_rx = 0;
        last_cyc = 0;
        q.push_back(8'h00);
        strobe(8'h00);
        for (int i = 0; i < 256; i++) begin
            wait_rx(700, lat, ok);
            if (!ok) begin
                chk("chain timeout", ok, 1'b1);
                break;
            end
            exp = q.pop_front();
            chk("chain rxdata", rxdata, exp);
            if (i > 0) chk("chain spacing", cyc - last_cyc, 320);
            last_cyc = cyc;
            n_rx++;
            tick(1);
            if (i < 255) begin
                q.push_back(8'(exp + 8'd1));
                strobe(8'(exp + 8'd1));
            end
        end
        chk("chain count", n_rx, 256);
        p0 = pulses;
        tick(400);
        chk("chain no extra pulse", pulses - p0, 0);
        chk("chain hold FF", rxdata, 8'hFF);

        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        p0 = pulses;
        strobe(a);
        tick(50);
        strobe(b);
        tick(20);
        strobe(c);
        wait_rx(700, lat, ok);
        chk("ovr first", rxdata, a);
        tick(1);
        wait_rx(700, lat, ok);
        chk("ovr second", rxdata, c);
        tick(400);
        chk("ovr pulse count", pulses - p0, 2);

        a = 8'($urandom);
        b = 8'($urandom);
        p0 = pulses;
        txdata = a;
        tx_enable = 1'b1;
        tick(1);
        txdata = b;
        tick(1);
        tx_enable = 1'b0;
        wait_rx(700, lat, ok);
        chk("held first", rxdata, a);
        tick(1);
        wait_rx(700, lat, ok);
        chk("held second", rxdata, b);
        last_good = b;
        tick(400);
        chk("held pulse count", pulses - p0, 2);

        loop = 1'b0;
        rx_drv = 1'b1;
        tick(50);
        p0 = pulses;
        rx_drv = 1'b0;
        tick(8);
        rx_drv = 1'b1;
        tick(100);
        chk("glitch no pulse", pulses - p0, 0);
        chk("glitch rxdata", rxdata, last_good);

        p0 = pulses;
        rx_frame(8'h3C, 1'b0);
        tick(100);
        chk("framing no pulse", pulses - p0, 0);
        chk("framing rxdata", rxdata, last_good);

        p0 = pulses;
        rx_frame(8'h5A, 1'b1);
        tick(60);
        chk("rx 5A pulse", pulses - p0, 1);
        chk("rx 5A data", rxdata, 8'h5A);
        last_good = 8'h5A;

        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            p0 = pulses;
            rx_frame(a, good);
            tick(60);
            if (good) last_good = a;
            chk("rx rand pulse", pulses - p0, good ? 1 : 0);
            chk("rx rand data", rxdata, last_good);
        end

        tick(20);
        strobe(8'h00);
        tick(99);
        chk("pre-reset tx low", tx, 1'b0);
        reset_ = 1'b0;
        tick(1);
        chk("abort tx high", tx, 1'b1);
        chk("abort rxdata", rxdata, 8'h00);
        chk("abort rx_enable", rx_enable, 1'b0);
        tick(2);
        reset_ = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx !== 1'b1) bad++;
            tick(1);
        end
        chk("post-reset tx idle", bad, 0);
        tx_frame_check(8'h81, "tx 81");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
